branch_resolve_unit: RTL and testbench

Parametrised, registered branch-resolution stage for the RV32 core. It evaluates all six conditional branches plus JAL/JALR in EX and compares the outcome against the fetch-stage prediction. It issues a one-cycle redirect on mispredict and trains an internal table of 2-bit saturating counters that fetch reads for direction prediction. It replaces the combinational offset-only branch compare.

---
 rtl/br_pkg.sv | 32 +++
 rtl/branch_hist_table.sv | 32 +++
 rtl/branch_resolve_unit.sv | 138 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/br_pkg.sv
// Shared types and helpers for branch resolution: op encoding and 2-bit
// saturating direction counters.
package br_pkg;

    typedef enum logic [3:0] {
        BR_NONE = 4'd0,
        BEQ     = 4'd1,
        BNE     = 4'd2,
        BLT     = 4'd3,
        BGE     = 4'd4,
        BLTU    = 4'd5,
        BGEU    = 4'd6,
        JAL     = 4'd7,
        JALR    = 4'd8
    } br_op_e;

    localparam int unsigned CTR_W     = 2;
    localparam logic [1:0]  CTR_RESET = 2'b01;

    function automatic logic [1:0] ctr_sat_inc(input logic [1:0] ctr);
        return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    endfunction

    function automatic logic [1:0] ctr_sat_dec(input logic [1:0] ctr);
        return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        return taken ? ctr_sat_inc(ctr) : ctr_sat_dec(ctr);
    endfunction

endpackage

// File: rtl/branch_hist_table.sv
// Direction counter table: combinational lookup, synchronous train/reset.
// A lookup in the same cycle as a write to the same index sees the old value.
module branch_hist_table
    import br_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [CTR_W-1:0] ctr_q [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            ctr_q[wr_idx] <= ctr_next(ctr_q[wr_idx], wr_taken);
        end
    end

    assign rd_taken = ctr_q[rd_idx][CTR_W-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: evaluates conditionals and jumps, flags
// mispredicts with a registered one-cycle redirect and trains the BHT.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 64,
    parameter int unsigned IDX_LO      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pred_pc_i,
    output logic            pred_taken_o,
    input  logic            ex_valid_i,
    input  logic [3:0]      ex_op_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic [XLEN-1:0] ex_imm_i,
    input  logic [XLEN-1:0] ex_rs1_i,
    input  logic [XLEN-1:0] ex_rs2_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [XLEN-1:0] link_o,
    output logic            misalign_o,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispred_cnt_o
);

    localparam int unsigned IDX_W   = $clog2(BHT_ENTRIES);
    localparam int unsigned STAT_W  = 32;

    br_op_e          op;
    logic            is_br_c;
    logic            is_cond_c;
    logic            taken_c;
    logic [XLEN-1:0] target_c;
    logic [XLEN-1:0] jalr_sum_c;
    logic [XLEN-1:0] pc4_c;
    logic            mispred_c;
    logic            misalign_c;
    logic            accept_c;
    logic [XLEN-1:0] correct_pc_c;

    logic            redirect_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic [XLEN-1:0] link_q;
    logic            misalign_q;
    logic [STAT_W-1:0] branch_cnt_q;
    logic [STAT_W-1:0] mispred_cnt_q;

    logic unused_pred_pc_bits;

    assign op         = br_op_e'(ex_op_i);
    assign pc4_c      = ex_pc_i + XLEN'(4);
    assign jalr_sum_c = ex_rs1_i + ex_imm_i;

    // Direction and target for the instruction currently in EX
    always_comb begin
        is_br_c   = 1'b1;
        is_cond_c = 1'b1;
        taken_c   = 1'b0;
        target_c  = ex_pc_i + ex_imm_i;
        case (op)
            BEQ:  taken_c = (ex_rs1_i == ex_rs2_i);
            BNE:  taken_c = (ex_rs1_i != ex_rs2_i);
            BLT:  taken_c = ($signed(ex_rs1_i) <  $signed(ex_rs2_i));
            BGE:  taken_c = ($signed(ex_rs1_i) >= $signed(ex_rs2_i));
            BLTU: taken_c = (ex_rs1_i <  ex_rs2_i);
            BGEU: taken_c = (ex_rs1_i >= ex_rs2_i);
            JAL: begin
                is_cond_c = 1'b0;
                taken_c   = 1'b1;
            end
            JALR: begin
                is_cond_c = 1'b0;
                taken_c   = 1'b1;
                target_c  = {jalr_sum_c[XLEN-1:1], 1'b0};
            end
            default: begin
                is_br_c   = 1'b0;
                is_cond_c = 1'b0;
            end
        endcase
    end

    // An active redirect means EX holds a wrong-path instruction this cycle
    assign accept_c     = ex_valid_i && is_br_c && !redirect_q;
    assign mispred_c    = (taken_c != ex_pred_taken_i) ||
                          (taken_c && (target_c != ex_pred_target_i));
    assign misalign_c   = taken_c && target_c[1];
    assign correct_pc_c = taken_c ? target_c : pc4_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            link_q        <= '0;
            misalign_q    <= 1'b0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            redirect_q    <= accept_c && mispred_c && !misalign_c;
            misalign_q    <= accept_c && misalign_c;
            redirect_pc_q <= accept_c ? correct_pc_c : '0;
            link_q        <= accept_c ? pc4_c : '0;
            if (accept_c && (branch_cnt_q != '1)) begin
                branch_cnt_q <= branch_cnt_q + STAT_W'(1);
            end
            if (accept_c && mispred_c && (mispred_cnt_q != '1)) begin
                mispred_cnt_q <= mispred_cnt_q + STAT_W'(1);
            end
        end
    end

    branch_hist_table #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (pred_pc_i[IDX_LO +: IDX_W]),
        .rd_taken (pred_taken_o),
        .wr_en    (accept_c && is_cond_c),
        .wr_idx   (ex_pc_i[IDX_LO +: IDX_W]),
        .wr_taken (taken_c)
    );

    assign unused_pred_pc_bits = ^pred_pc_i;

    assign redirect_o    = redirect_q;
    assign redirect_pc_o = redirect_pc_q;
    assign link_o        = link_q;
    assign misalign_o    = misalign_q;
    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected outputs queued per EX
// cycle from a reference model, compared one cycle later.
module tb_branch_resolve_unit;
    import br_pkg::*;

    typedef struct packed {
        logic        redirect;
        logic [31:0] rpc;
        logic [31:0] link;
        logic        misalign;
        logic [31:0] br;
        logic [31:0] mp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic        ex_valid;
    logic [3:0]  ex_op;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc, link;
    logic        misalign;
    logic [31:0] branch_cnt, mispred_cnt;

    int unsigned errors = 0;
    int unsigned checks = 0;

    exp_t        exp_q[$];
    logic [1:0]  m_bht [64];
    logic [31:0] m_br, m_mp;
    logic        m_redirect;

    branch_resolve_unit dut (
        .clk              (clk),
        .rst              (rst),
        .pred_pc_i        (pred_pc),
        .pred_taken_o     (pred_taken),
        .ex_valid_i       (ex_valid),
        .ex_op_i          (ex_op),
        .ex_pc_i          (ex_pc),
        .ex_imm_i         (ex_imm),
        .ex_rs1_i         (ex_rs1),
        .ex_rs2_i         (ex_rs2),
        .ex_pred_taken_i  (ex_pred_taken),
        .ex_pred_target_i (ex_pred_target),
        .redirect_o       (redirect),
        .redirect_pc_o    (redirect_pc),
        .link_o           (link),
        .misalign_o       (misalign),
        .branch_cnt_o     (branch_cnt),
        .mispred_cnt_o    (mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        m_br = '0;
        m_mp = '0;
        m_redirect = 1'b0;
        exp_q.delete();
    endtask

    // Hold rst for one edge with live EX traffic, then check the cleared state
    task automatic do_reset(input logic [3:0] op);
        rst = 1'b1;
        ex_valid = 1'b1;
        ex_op = op;
        @(posedge clk); #1;
        rst = 1'b0;
        ex_valid = 1'b0;
        model_reset();
        chk("rst_redirect", redirect, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_link", link, 0);
        chk("rst_misalign", misalign, 0);
        chk("rst_brcnt", branch_cnt, 0);
        chk("rst_mpcnt", mispred_cnt, 0);
        pred_pc = 32'h100;
        #1;
        chk("rst_pred", pred_taken, 0);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] a, input logic [31:0] b,
                         input logic pt, input logic [31:0] ptgt);
        exp_t        e;
        exp_t        got;
        logic        tk;
        logic        cond;
        logic        acc;
        logic        mp;
        logic [31:0] tgt;
        logic [5:0]  pidx;
        ex_valid = v; ex_op = op; ex_pc = pc; ex_imm = imm;
        ex_rs1 = a; ex_rs2 = b; ex_pred_taken = pt; ex_pred_target = ptgt;
        #1;
        pidx = pred_pc[7:2];
        chk("pred_taken", pred_taken, m_bht[pidx][1]);
        cond = (op >= 4'd1) && (op <= 4'd6);
        case (op)
            4'd1: tk = (a == b);
            4'd2: tk = (a != b);
            4'd3: tk = ($signed(a) < $signed(b));
            4'd4: tk = !($signed(a) < $signed(b));
            4'd5: tk = (a < b);
            4'd6: tk = !(a < b);
            4'd7, 4'd8: tk = 1'b1;
            default: tk = 1'b0;
        endcase
        tgt = (op == 4'd8) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
        acc = v && (op >= 4'd1) && (op <= 4'd8) && !m_redirect;
        mp  = (tk != pt) || (tk && (tgt != ptgt));
        e = '0;
        if (acc) begin
            e.misalign = tk && tgt[1];
            e.redirect = mp && !e.misalign;
            e.rpc      = tk ? tgt : pc + 32'd4;
            e.link     = pc + 32'd4;
            if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
            if (mp && (m_mp != 32'hFFFF_FFFF)) m_mp = m_mp + 1;
            if (cond) begin
                if (tk && m_bht[pc[7:2]] != 2'b11) m_bht[pc[7:2]] = m_bht[pc[7:2]] + 1;
                if (!tk && m_bht[pc[7:2]] != 2'b00) m_bht[pc[7:2]] = m_bht[pc[7:2]] - 1;
            end
        end
        m_redirect = e.redirect;
        e.br = m_br;
        e.mp = m_mp;
        exp_q.push_back(e);
        @(posedge clk); #1;
        chk("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = '{redirect, redirect_pc, link, misalign, branch_cnt, mispred_cnt};
            chk("redirect", got.redirect, e.redirect);
            chk("redirect_pc", got.rpc, e.rpc);
            chk("link", got.link, e.link);
            chk("misalign", got.misalign, e.misalign);
            chk("branch_cnt", got.br, e.br);
            chk("mispred_cnt", got.mp, e.mp);
        end
    endtask

    task automatic idle();
        drive(1'b0, BR_NONE, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] pc, imm, a, b, tg;
        rst = 1'b1;
        pred_pc = 32'h100;
        ex_valid = 1'b0; ex_op = BR_NONE; ex_pc = '0; ex_imm = '0;
        ex_rs1 = '0; ex_rs2 = '0; ex_pred_taken = 1'b0; ex_pred_target = '0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(BEQ);

        // BEQ taken, predicted not-taken: redirect to pc+imm, then trained
        drive(1, BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 0, 32'h0);
        idle();
        drive(1, BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1, 32'h120);

        // Signed vs unsigned compare on the same operands
        drive(1, BLT, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, 32'h0);
        idle();
        drive(1, BLTU, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1, 32'h240);
        idle();

        // JALR LSB clear and misaligned targets, then JAL redirect
        drive(1, JALR, 32'h300, 32'd2, 32'h2001, 32'h0, 1, 32'h2002);
        drive(1, JALR, 32'h304, 32'd2, 32'h2000, 32'h0, 1, 32'h2002);
        drive(1, JAL, 32'h400, 32'h100, 32'h0, 32'h0, 0, 32'h0);
        idle();

        // Back-to-back mispredicts: second is wrong-path
        drive(1, BNE, 32'h500, 32'h8, 32'd1, 32'd2, 0, 32'h0);
        drive(1, BNE, 32'h504, 32'h8, 32'd1, 32'd2, 0, 32'h0);
        idle();
        drive(1, BEQ, 32'h600, 32'h8, 32'd1, 32'd2, 0, 32'h0);
        drive(1, BEQ, 32'h604, 32'h8, 32'd1, 32'd2, 0, 32'h0);

        // Saturate index 3 taken; lookup concurrent with update sees old value
        pred_pc = 32'hC;
        repeat (4) drive(1, BGE, 32'hC, 32'h10, 32'd5, 32'd5, 1, 32'h1C);
        drive(1, BGEU, 32'hC, 32'h10, 32'd0, 32'd1, 0, 32'h0);
        idle();

        // Mixed random traffic
        for (int i = 0; i < 300; i++) begin
            op  = 4'($urandom_range(0, 9));
            pc  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            imm = {20'h0, 11'($urandom_range(0, 2047)), 1'b0};
            a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            tg  = (op == 4'd8) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
            if ($urandom_range(0, 3) == 0) tg = tg + 32'd4;
            pred_pc = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            drive($urandom_range(0, 9) != 0, op, pc, imm, a, b,
                  1'($urandom_range(0, 1)), tg);
        end
        idle();

        // Statistics saturate at all-ones
        force dut.branch_cnt_q = 32'hFFFF_FFFF;
        force dut.mispred_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.branch_cnt_q;
        release dut.mispred_cnt_q;
        m_br = 32'hFFFF_FFFF;
        m_mp = 32'hFFFF_FFFF;
        pred_pc = 32'h100;
        drive(1, BEQ, 32'h100, 32'h20, 32'd7, 32'd7, 0, 32'h0);

        // Reset during the redirect cycle clears everything
        do_reset(BNE);
        drive(1, BNE, 32'h700, 32'h10, 32'd3, 32'd4, 1, 32'h710);
        drive(1, BEQ, 32'h700, 32'h10, 32'd3, 32'd4, 1, 32'h710);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
